// File: rtl/johnson_phase_decoder_pkg.sv
// Shared definitions for the Johnson phase decoder: FSM encoding and the
// 8-entry legal-code table (entry i holds the q3..q0 code for phase i).
package johnson_phase_decoder_pkg;

    localparam int unsigned CODE_W  = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned PHASE_N = 8;
    localparam int unsigned MATCH_W = 3;
    localparam int unsigned REV_W   = 8;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    localparam logic [PHASE_N-1:0][CODE_W-1:0] JC_TABLE = {
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b0111, 4'b0011, 4'b0001, 4'b0000
    };

    function automatic logic [PHASE_N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = PHASE_N'(1) << idx;
    endfunction

endpackage

// File: rtl/johnson_code_lookup.sv
// Combinational code-to-phase lookup; flags any code absent from the table.
module johnson_code_lookup
    import johnson_phase_decoder_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [IDX_W-1:0]  o_idx_c,
    output logic              o_legal_c
);

    always_comb begin
        o_idx_c   = '0;
        o_legal_c = 1'b0;
        for (int i = 0; i < int'(PHASE_N); i++) begin
            if (i_code == JC_TABLE[i]) begin
                o_idx_c   = IDX_W'(i);
                o_legal_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson counter into a phase index, tracks sequence lock,
// flags slips and illegal codes, and counts revolutions while locked.
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CODE_W-1:0]   q,
    input  logic                enable,
    input  logic                clear_err,
    output logic [IDX_W-1:0]    phase_idx,
    output logic [PHASE_N-1:0]  phase_onehot,
    output logic                valid,
    output logic                locked,
    output logic                slip,
    output logic                error,
    output logic [REV_W-1:0]    rev_count
);

    logic [1:0]          r_state;
    logic [IDX_W-1:0]    r_phase_idx;
    logic [PHASE_N-1:0]  r_phase_onehot;
    logic                r_valid;
    logic                r_locked;
    logic                r_slip;
    logic                r_error;
    logic [REV_W-1:0]    r_rev_count;
    logic [MATCH_W-1:0]  r_match;
    logic                r_prev_legal;

    logic [IDX_W-1:0]    w_code_idx;
    logic                w_code_legal;
    logic                w_seq_ok;
    logic [MATCH_W-1:0]  w_match_inc;
    logic [1:0]          w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_valid_nxt;
    logic                w_slip_nxt;
    logic [REV_W-1:0]    w_rev_nxt;
    logic [MATCH_W-1:0]  w_match_nxt;
    logic                w_prev_legal_nxt;

    johnson_code_lookup u_lookup (
        .i_code    (q),
        .o_idx_c   (w_code_idx),
        .o_legal_c (w_code_legal)
    );

    // Next-state logic; priority is clear_err > hold > illegal > decode.
    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_phase_idx;
        w_valid_nxt      = r_valid;
        w_slip_nxt       = 1'b0;
        w_rev_nxt        = r_rev_count;
        w_match_nxt      = r_match;
        w_prev_legal_nxt = r_prev_legal;
        w_seq_ok         = r_prev_legal && (w_code_idx == IDX_W'(r_phase_idx + IDX_W'(1)));
        w_match_inc      = MATCH_W'(r_match + MATCH_W'(1));

        if (clear_err) begin
            w_state_nxt      = ST_SEARCH;
            w_valid_nxt      = 1'b0;
            w_match_nxt      = '0;
            w_rev_nxt        = '0;
            w_prev_legal_nxt = 1'b0;
        end else if (!enable) begin
            w_slip_nxt = 1'b0;
        end else if (!w_code_legal) begin
            w_state_nxt      = ST_ERROR;
            w_valid_nxt      = 1'b0;
            w_prev_legal_nxt = 1'b0;
        end else if (r_state != ST_ERROR) begin
            w_idx_nxt        = w_code_idx;
            w_valid_nxt      = 1'b1;
            w_prev_legal_nxt = 1'b1;
            if (r_state == ST_LOCKED) begin
                if (!w_seq_ok) begin
                    w_state_nxt = ST_SEARCH;
                    w_match_nxt = '0;
                    w_slip_nxt  = 1'b1;
                end else if ((r_phase_idx == IDX_W'(PHASE_N - 1)) && (r_rev_count != '1)) begin
                    w_rev_nxt = REV_W'(r_rev_count + REV_W'(1));
                end
            end else if (w_seq_ok) begin
                w_match_nxt = w_match_inc;
                if (w_match_inc == MATCH_W'(LOCK_COUNT)) begin
                    w_state_nxt = ST_LOCKED;
                end
            end else begin
                w_match_nxt = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_SEARCH;
            r_phase_idx    <= '0;
            r_phase_onehot <= '0;
            r_valid        <= 1'b0;
            r_locked       <= 1'b0;
            r_slip         <= 1'b0;
            r_error        <= 1'b0;
            r_rev_count    <= '0;
            r_match        <= '0;
            r_prev_legal   <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase_idx    <= w_idx_nxt;
            r_phase_onehot <= w_valid_nxt ? idx_to_onehot(w_idx_nxt) : '0;
            r_valid        <= w_valid_nxt;
            r_locked       <= (w_state_nxt == ST_LOCKED);
            r_slip         <= w_slip_nxt;
            r_error        <= (w_state_nxt == ST_ERROR);
            r_rev_count    <= w_rev_nxt;
            r_match        <= w_match_nxt;
            r_prev_legal   <= w_prev_legal_nxt;
        end
    end

    assign phase_idx    = r_phase_idx;
    assign phase_onehot = r_phase_onehot;
    assign valid        = r_valid;
    assign locked       = r_locked;
    assign slip         = r_slip;
    assign error        = r_error;
    assign rev_count    = r_rev_count;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed self-checking bench for johnson_phase_decoder (LOCK_COUNT = 2).
module tb_johnson_phase_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] q;
    logic       enable;
    logic       clear_err;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       valid;
    logic       locked;
    logic       slip;
    logic       error;
    logic [7:0] rev_count;

    int checks   = 0;
    int failures = 0;

    johnson_phase_decoder #(.LOCK_COUNT(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .q            (q),
        .enable       (enable),
        .clear_err    (clear_err),
        .phase_idx    (phase_idx),
        .phase_onehot (phase_onehot),
        .valid        (valid),
        .locked       (locked),
        .slip         (slip),
        .error        (error),
        .rev_count    (rev_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] code_of(input int idx);
        case (idx % 8)
            0: code_of = 4'b0000;
            1: code_of = 4'b0001;
            2: code_of = 4'b0011;
            3: code_of = 4'b0111;
            4: code_of = 4'b1111;
            5: code_of = 4'b1110;
            6: code_of = 4'b1100;
            default: code_of = 4'b1000;
        endcase
    endfunction

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [3:0] qv, input logic en, input logic clr, input logic rst);
        @(negedge clock);
        q = qv; enable = en; clear_err = clr; reset = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_idx, input logic [7:0] e_oh,
                             input logic e_valid, input logic e_locked, input logic e_slip,
                             input logic e_error, input logic [7:0] e_rev);
        check({tag, ".idx"},    32'(phase_idx),    32'(e_idx));
        check({tag, ".oh"},     32'(phase_onehot), 32'(e_oh));
        check({tag, ".valid"},  32'(valid),        32'(e_valid));
        check({tag, ".locked"}, 32'(locked),       32'(e_locked));
        check({tag, ".slip"},   32'(slip),         32'(e_slip));
        check({tag, ".error"},  32'(error),        32'(e_error));
        check({tag, ".rev"},    32'(rev_count),    32'(e_rev));
    endtask

    initial begin
        reset = 1'b1; q = 4'b0000; enable = 1'b0; clear_err = 1'b0;

        step(4'b0000, 1'b0, 1'b0, 1'b1);
        check_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Acquire lock: 0000, 0001, 0011
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check_all("acq0", 3'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        check("acq1.locked", 32'(locked), 32'd0);
        step(4'b0011, 1'b1, 1'b0, 1'b0);
        check_all("acq2", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // 16 more in-sequence steps: wraps 7->0 twice, ends at idx 2
        for (int k = 3; k < 19; k++) begin
            step(code_of(k), 1'b1, 1'b0, 1'b0);
            check("run.slip", 32'(slip), 32'd0);
            check("run.locked", 32'(locked), 32'd1);
        end
        check_all("run16", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);

        // Slip from idx 3 back to 0, then relock
        step(4'b0111, 1'b1, 1'b0, 1'b0);
        check_all("at3", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check_all("slip", 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h02);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        check_all("slip+1", 3'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02);
        step(4'b0011, 1'b1, 1'b0, 1'b0);
        check_all("relock", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h02);

        // Illegal code: sticky error, phase_idx holds last legal value
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        check_all("err", 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02);
        for (int k = 3; k < 8; k++) begin
            step(code_of(k), 1'b1, 1'b0, 1'b0);
            check("err.sticky", 32'(error), 32'd1);
            check("err.valid", 32'(valid), 32'd0);
            check("err.oh", 32'(phase_onehot), 32'h00);
        end
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        check("clr.error", 32'(error), 32'd0);
        check("clr.rev", 32'(rev_count), 32'h00);
        check("clr.valid", 32'(valid), 32'd0);
        check("clr.locked", 32'(locked), 32'd0);
        check("clr.oh", 32'(phase_onehot), 32'h00);

        // Back in SEARCH: first code after clear cannot count as a match
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        check("search.nolock", 32'(locked), 32'd0);
        step(4'b0011, 1'b1, 1'b0, 1'b0);
        check_all("lock2", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Hold while q changes
        step(4'b0111, 1'b0, 1'b0, 1'b0);
        check_all("hold0", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        check_all("hold1", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(4'b1110, 1'b0, 1'b0, 1'b0);
        check_all("hold2", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        step(4'b0111, 1'b1, 1'b0, 1'b0);
        check_all("resume", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

        // Five revolutions from idx 3, then reset overrides clear_err/enable
        for (int k = 4; k < 44; k++) step(code_of(k), 1'b1, 1'b0, 1'b0);
        check_all("rev5", 3'd3, 8'h08, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05);
        step(4'b0101, 1'b1, 1'b1, 1'b1);
        check_all("midreset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Revolution counter saturates at 8'hFF
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0, 1'b0);
        for (int k = 3; k < 3 + 8 * 260; k++) step(code_of(k), 1'b1, 1'b0, 1'b0);
        check_all("sat", 3'd2, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);

        // clear_err while LOCKED forces SEARCH and clears rev_count
        step(4'b0111, 1'b1, 1'b1, 1'b0);
        check_all("clrlock", 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Illegal code from SEARCH also enters ERROR
        step(4'b1010, 1'b1, 1'b0, 1'b0);
        check_all("errsearch", 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
